reglist_sequencer: RTL and testbench

- Multi-register transfer sequencer for the CPU's load/store-multiple path.
- Latches a register-list bit mask at start.
- Repeatedly finds the lowest set bit, issues one transfer request per set bit with a stepped address, then clears that bit.
- Sits between the decode stage, which supplies mask and base, and the memory/register-file port, which accepts the requests.

---
 rtl/reglist_sequencer.sv | 123 ++++++++++++
 tb/tb_reglist_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reglist_sequencer.sv
// Load/store-multiple register-list sequencer: one transfer request per set mask bit.
// Optional REGLIST_DESCENDING_EN: highest bit first, pre-decrementing addresses.
module reglist_sequencer #(
  parameter int N_REGS = 32,
  parameter int IDX_W  = 5,
  parameter int ADDR_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_REGS-1:0] reg_mask,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [IDX_W-1:0]  req_idx,
  output logic [ADDR_W-1:0] req_addr,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    xfer_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

  state_t            state;
  logic [N_REGS-1:0] mask;
  logic [N_REGS-1:0] mask_next;
  logic [IDX_W-1:0]  sel_idx;
  logic              accept;

  assign accept = (state == ISSUE) && req_valid && req_ready;

  // Mask as it will stand after this edge; the search runs on it so the
  // registered req_idx is ready the cycle the new mask takes effect.
  always_comb begin
    mask_next = mask;
    if (state == IDLE && start)
      mask_next = reg_mask;
    else if (accept)
      mask_next = mask & ~(N_REGS'(1) << req_idx);
  end

  always_comb begin
    sel_idx = '0;
`ifdef REGLIST_DESCENDING_EN
    for (int i = 0; i < N_REGS; i++)
      if (mask_next[i]) sel_idx = i[IDX_W-1:0];
`else
    for (int i = N_REGS - 1; i >= 0; i--)
      if (mask_next[i]) sel_idx = i[IDX_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask       <= '0;
      req_valid  <= 1'b0;
      req_idx    <= '0;
      req_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask       <= reg_mask;
            xfer_count <= '0;
            busy       <= 1'b1;
            if (|reg_mask) begin
              state     <= ISSUE;
              req_valid <= 1'b1;
              req_idx   <= sel_idx;
`ifdef REGLIST_DESCENDING_EN
              req_addr  <= base_addr - STEP_A;
`else
              req_addr  <= base_addr;
`endif
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            mask       <= mask_next;
            xfer_count <= xfer_count + (IDX_W + 1)'(1);
`ifdef REGLIST_DESCENDING_EN
            req_addr   <= req_addr - STEP_A;
`else
            req_addr   <= req_addr + STEP_A;
`endif
            if (mask_next == '0) begin
              state     <= DONE;
              req_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              req_idx <= sel_idx;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          req_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reglist_sequencer.sv
// Randomized bench for reglist_sequencer against a list-level transfer model.
module tb_reglist_sequencer;

  localparam int N_REGS = 32;
  localparam int IDX_W  = 5;
  localparam int ADDR_W = 32;
  localparam int STEP   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [N_REGS-1:0] reg_mask = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              req_valid;
  logic              req_ready = 1'b0;
  logic [IDX_W-1:0]  req_idx;
  logic [ADDR_W-1:0] req_addr;
  logic              busy;
  logic              done;
  logic [IDX_W:0]    xfer_count;

  int vectors = 0;
  int miscompares = 0;

  int               exp_idx[$];
  logic [31:0]      exp_addr[$];

  reglist_sequencer #(.N_REGS(N_REGS), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reg_mask(reg_mask), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_addr(req_addr),
    .busy(busy), .done(done), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected transfer list straight from the mask: bit order and address stride.
  task automatic build_model(input logic [31:0] m, input logic [31:0] b);
    int k;
    exp_idx.delete();
    exp_addr.delete();
    k = 0;
`ifdef REGLIST_DESCENDING_EN
    for (int i = N_REGS - 1; i >= 0; i--)
      if (m[i]) begin
        exp_idx.push_back(i);
        exp_addr.push_back(b - 32'(STEP * (k + 1)));
        k++;
      end
`else
    for (int i = 0; i < N_REGS; i++)
      if (m[i]) begin
        exp_idx.push_back(i);
        exp_addr.push_back(b + 32'(STEP * k));
        k++;
      end
`endif
  endtask

  task automatic run_list(input logic [31:0] m, input logic [31:0] b, input int prob, input int stall_first);
    int n, k, cycles, stalls;
    build_model(m, b);
    n = exp_idx.size();
    start = 1'b1; reg_mask = m; base_addr = b; req_ready = 1'b0;
    step();
    start = 1'b0; reg_mask = $urandom; base_addr = $urandom;
    check("busy_after_start", busy, 1);
    k = 0; cycles = 0; stalls = 0;
    while (k < n && cycles < 2000) begin
      check("req_valid", req_valid, 1);
      check("req_idx", req_idx, exp_idx[k]);
      check("req_addr", req_addr, exp_addr[k]);
      check("done_low", done, 0);
      if (k == 0 && stalls < stall_first) begin
        req_ready = 1'b0;
        stalls++;
      end else begin
        req_ready = ($urandom_range(0, 99) < prob);
      end
      if (req_ready) k++;
      cycles++;
      step();
    end
    if (k < n) check("timeout", k, n);
    if (prob >= 100 && stall_first == 0) check("cycles", cycles, n);
    req_ready = $urandom_range(0, 1);
    check("done_pulse", done, 1);
    check("valid_at_done", req_valid, 0);
    check("busy_at_done", busy, 1);
    check("xfer_count", xfer_count, n);
    step();
    check("done_clear", done, 0);
    check("busy_clear", busy, 0);
    check("count_hold", xfer_count, n);
    req_ready = 1'b0;
    $display("list mask=%08h base=%08h transfers=%0d cycles=%0d", m, b, n, cycles);
  endtask

  initial begin
    logic [31:0] m;
    #12;
    check("rst_valid", req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", xfer_count, 0);
    check("rst_idx", req_idx, 0);
    check("rst_addr", req_addr, 0);
    rst_n = 1'b1;
    step();

    run_list(32'h0000_0015, 32'h100, 100, 0);
    run_list(32'h0000_0000, 32'h300, 100, 0);
    run_list(32'h8000_0001, 32'h400, 100, 3);
    run_list(32'hFFFF_FFFF, 32'hFFFF_FFF8, 100, 0);

    // Start during busy is ignored, then reset abandons the list mid-way.
    start = 1'b1; reg_mask = 32'h15; base_addr = 32'h200;
    step();
    start = 1'b0; req_ready = 1'b1;
    step();
    req_ready = 1'b0;
`ifdef REGLIST_DESCENDING_EN
    check("busy_idx", req_idx, 2);
    check("busy_addr", req_addr, 32'h1F8);
`else
    check("busy_idx", req_idx, 2);
    check("busy_addr", req_addr, 32'h204);
`endif
    start = 1'b1; reg_mask = 32'hF0; base_addr = 32'h0;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("ign_idx", req_idx, 2);
`ifdef REGLIST_DESCENDING_EN
      check("ign_addr", req_addr, 32'h1F8);
`else
      check("ign_addr", req_addr, 32'h204);
`endif
      check("ign_count", xfer_count, 1);
      check("ign_busy", busy, 1);
      step();
    end
    rst_n = 1'b0;
    #1;
    check("arst_valid", req_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_count", xfer_count, 0);
    check("arst_idx", req_idx, 0);
    check("arst_addr", req_addr, 0);
    step();
    check("arst_nodone", done, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_idle", busy, 0);
    run_list(32'h0000_0015, 32'h100, 100, 0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0: m = 32'h0;
        1: m = 32'hFFFF_FFFF;
        2: m = 32'h1 << $urandom_range(0, 31);
        3: m = $urandom & $urandom & $urandom;
        default: m = $urandom;
      endcase
      run_list(m, $urandom, $urandom_range(30, 100), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
